ptc_tap_encoder: RTL and testbench

- Inverse of the PTC 4-to-16 coarse-tap decoder. Captures the 16-bit one-hot coarse-tap vector T, returns it to the controller clock domain, and re-encodes it into the 4-bit coarse code Q[9:6].
- Used for loop readback and self-check of the coarse delay line.
- Synchronises the vector, debounces it over several samples, and checks it is legal one-hot.
- Delivers each new stable code over a valid/ready handshake.

---
 rtl/ptc_pkg.sv | 25 ++
 rtl/ptc_tap_encoder_if.sv | 9 +
 rtl/ptc_sync_vec.sv | 18 +
 rtl/ptc_tap_encoder.sv | 127 ++++++++++++
 tb/tb_ptc_tap_encoder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/ptc_pkg.sv
// ptc_pkg: shared state type, widths and one-hot decode for the PTC coarse-tap encoder.
package ptc_pkg;
    localparam int PTC_TAP_W  = 16;
    localparam int PTC_CODE_W = 4;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, ERR} ptc_state_e;

    typedef struct packed {
        logic                  legal;
        logic [PTC_CODE_W-1:0] code;
    } ptc_dec_t;

    // All-zero is code 0; bit k (0..14) is code k+1; bit 15 or multi-hot is illegal.
    function automatic ptc_dec_t onehot_to_code(input logic [PTC_TAP_W-1:0] v);
        ptc_dec_t r;
        r.legal = (v == '0);
        r.code  = '0;
        for (int k = 0; k < PTC_TAP_W - 1; k++)
            if (v == (PTC_TAP_W'(1) << k)) begin
                r.legal = 1'b1;
                r.code  = PTC_CODE_W'(k + 1);
            end
        return r;
    endfunction
endpackage

// File: rtl/ptc_tap_encoder_if.sv
// ptc_tap_encoder_if: valid/ready delivery channel for accepted coarse codes.
interface ptc_tap_encoder_if;
    import ptc_pkg::*;
    logic [PTC_CODE_W-1:0] code_out;
    logic                  code_valid;
    logic                  code_ready;
    modport master (output code_out, output code_valid, input code_ready);
    modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/ptc_sync_vec.sv
// ptc_sync_vec: multi-bit flop chain bringing an asynchronous vector into the clk domain.
module ptc_sync_vec #(
    parameter int W      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [STAGES-1:0][W-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/ptc_tap_encoder.sv
// ptc_tap_encoder: synchronise, debounce and one-hot-check the coarse-tap vector, re-encode to Q[9:6].
// Define PTC_TB_CHECK_EN to add the complement vector tb_in and its cross-check.
module ptc_tap_encoder import ptc_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [PTC_TAP_W-1:0] t_in,
`ifdef PTC_TB_CHECK_EN
    input  logic [PTC_TAP_W-1:0] tb_in,
`endif
    ptc_tap_encoder_if.master    bus,
    output logic                 locked,
    output logic                 onehot_err
);
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    logic [PTC_TAP_W-1:0]  w_s, r_s_prev;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    ptc_state_e            r_state, w_state_nxt;
    ptc_dec_t              w_dec;
    logic                  w_legal, w_same, w_cand_v, w_free, w_diff;
    logic [PTC_CODE_W-1:0] r_code, r_pend;
    logic                  r_valid, r_pend_v, r_have, r_err;

    ptc_sync_vec #(.W(PTC_TAP_W), .STAGES(SYNC_STAGES)) u_sync_t (
        .clk(clk), .rst_n(rst_n), .i_d(t_in), .o_q(w_s)
    );

`ifdef PTC_TB_CHECK_EN
    logic [PTC_TAP_W-1:0] w_tb_s, r_tb_prev;

    ptc_sync_vec #(.W(PTC_TAP_W), .STAGES(SYNC_STAGES)) u_sync_tb (
        .clk(clk), .rst_n(rst_n), .i_d(tb_in), .o_q(w_tb_s)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_tb_prev <= '0;
        else        r_tb_prev <= w_tb_s;

    always_comb begin
        w_dec   = onehot_to_code(w_s);
        w_legal = w_dec.legal && (w_tb_s == ~w_s);
        w_same  = (w_s == r_s_prev) && (w_tb_s == r_tb_prev);
    end
`else
    always_comb begin
        w_dec   = onehot_to_code(w_s);
        w_legal = w_dec.legal;
        w_same  = (w_s == r_s_prev);
    end
`endif

    assign w_cnt_nxt = (!en || !w_legal || !w_same) ? '0 :
                       (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Lock on the cycle the counter saturates so the candidate lands with the new count.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_v    = 1'b0;
        if (!en) w_state_nxt = IDLE;
        else case (r_state)
            IDLE:    w_state_nxt = SETTLE;
            SETTLE: begin
                if (!w_legal) w_state_nxt = ERR;
                else if (w_cnt_nxt == CNT_MAX) begin
                    w_state_nxt = LOCKED;
                    w_cand_v    = 1'b1;
                end
            end
            LOCKED:  w_state_nxt = !w_legal ? ERR : !w_same ? SETTLE : LOCKED;
            ERR:     w_state_nxt = w_legal ? SETTLE : ERR;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_free = !r_valid || bus.code_ready;
    assign w_diff = !r_have || (w_dec.code != r_code);

    // A stalled channel parks only the newest differing candidate in r_pend.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state  <= IDLE;
            r_s_prev <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_have   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s_prev <= w_s;
            r_cnt    <= w_cnt_nxt;
            r_err    <= en && (r_err || w_state_nxt == ERR);
            if (!en) begin
                r_valid  <= 1'b0;
                r_pend_v <= 1'b0;
                r_have   <= 1'b0;
            end else if (w_free) begin
                if (w_cand_v) begin
                    r_valid  <= w_diff;
                    r_pend_v <= 1'b0;
                    if (w_diff) begin
                        r_code <= w_dec.code;
                        r_have <= 1'b1;
                    end
                end else if (r_pend_v) begin
                    r_code   <= r_pend;
                    r_valid  <= 1'b1;
                    r_pend_v <= 1'b0;
                end else r_valid <= 1'b0;
            end else if (w_cand_v) begin
                r_pend   <= w_dec.code;
                r_pend_v <= w_diff;
            end
        end

    assign bus.code_out   = r_code;
    assign bus.code_valid = r_valid;
    assign locked         = (r_state == LOCKED);
    assign onehot_err     = r_err;
endmodule

// File: tb/tb_ptc_tap_encoder.sv
// tb_ptc_tap_encoder: directed checks with a scoreboard of expected deliveries.
module tb_ptc_tap_encoder;
    import ptc_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [15:0] t_in = '0;
    logic        locked, onehot_err;
    int          n_vec = 0, n_err = 0;
    logic [3:0]  sb[$];
    logic        any_v, drop;

    always #5 clk = ~clk;

    ptc_tap_encoder_if bus();

`ifdef PTC_TB_CHECK_EN
    logic [15:0] tb_in, tb_flip = '0;
    always_comb tb_in = ~t_in ^ tb_flip;
`endif

    ptc_tap_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .t_in(t_in),
`ifdef PTC_TB_CHECK_EN
        .tb_in(tb_in),
`endif
        .bus(bus), .locked(locked), .onehot_err(onehot_err)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (rst_n && bus.code_valid && bus.code_ready) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_delivery: got code %0d, expected none", bus.code_out);
            end
            if (sb.size() > 0) chk("delivery", 16'(bus.code_out), 16'(sb.pop_front()));
        end

    initial begin
        bus.code_ready = 1'b0;
        tick(2);
        chk("rst_code", 16'(bus.code_out), 16'd0);
        chk("rst_valid", 16'(bus.code_valid), 16'd0);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_err", 16'(onehot_err), 16'd0);
        // reset while a code is held undelivered
        rst_n = 1'b1; en = 1'b1; t_in = 16'h0010;
        tick(10);
        chk("pre_rst_valid", 16'(bus.code_valid), 16'd1);
        chk("pre_rst_code", 16'(bus.code_out), 16'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 16'(bus.code_valid), 16'd0);
        chk("async_rst_code", 16'(bus.code_out), 16'd0);
        chk("async_rst_locked", 16'(locked), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; bus.code_ready = 1'b1; sb.push_back(4'd5);
        tick(6);
        chk("lat_early", 16'(bus.code_valid), 16'd0);
        tick(1);
        chk("lat_valid", 16'(bus.code_valid), 16'd1);
        chk("lat_code", 16'(bus.code_out), 16'd5);
        chk("lat_locked", 16'(locked), 16'd1);
        tick(1);
        chk("lat_pulse", 16'(bus.code_valid), 16'd0);
        // encoding sweep
        foreach (sb[i]) ;
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v;
            logic [3:0]  c;
            v = (i == 0) ? 16'h0001 : (i == 1) ? 16'h4000 : 16'h0000;
            c = (i == 0) ? 4'd1 : (i == 1) ? 4'd15 : 4'd0;
            t_in = v; sb.push_back(c);
            tick(6);
            chk("sweep_early", 16'(bus.code_valid), 16'd0);
            tick(1);
            chk("sweep_valid", 16'(bus.code_valid), 16'd1);
            chk("sweep_code", 16'(bus.code_out), 16'(c));
            tick(1);
            chk("sweep_pulse", 16'(bus.code_valid), 16'd0);
        end
        // illegal vectors
        t_in = 16'h0003;
        tick(5);
        chk("multi_err", 16'(onehot_err), 16'd1);
        chk("multi_locked", 16'(locked), 16'd0);
        t_in = 16'h8000;
        tick(5);
        chk("b15_err", 16'(onehot_err), 16'd1);
        chk("b15_locked", 16'(locked), 16'd0);
        t_in = 16'h0004; sb.push_back(4'd3);
        tick(6);
        chk("err_rec_early", 16'(bus.code_valid), 16'd0);
        tick(1);
        chk("err_rec_code", 16'(bus.code_out), 16'd3);
        chk("err_sticky", 16'(onehot_err), 16'd1);
        en = 1'b0;
        tick(1);
        chk("en_clr_err", 16'(onehot_err), 16'd0);
        chk("en_clr_locked", 16'(locked), 16'd0);
        en = 1'b1; sb.push_back(4'd3);
        tick(10);
        // glitch rejection
        t_in = 16'h0002; sb.push_back(4'd2);
        tick(10);
        chk("glitch_pre_locked", 16'(locked), 16'd1);
        any_v = 1'b0; drop = 1'b0;
        t_in = 16'h0020;
        for (int i = 0; i < 17; i++) begin
            if (i == 3) t_in = 16'h0002;
            tick(1);
            any_v |= bus.code_valid;
            drop  |= !locked;
        end
        chk("glitch_no_valid", 16'(any_v), 16'd0);
        chk("glitch_drop", 16'(drop), 16'd1);
        chk("glitch_relock", 16'(locked), 16'd1);
        // backpressure, latest-wins
        bus.code_ready = 1'b0; t_in = 16'h0008;
        tick(10);
        chk("bp_valid", 16'(bus.code_valid), 16'd1);
        chk("bp_code", 16'(bus.code_out), 16'd4);
        t_in = 16'h0100;
        tick(10);
        chk("bp_frozen1", 16'(bus.code_out), 16'd4);
        t_in = 16'h0200;
        tick(10);
        chk("bp_frozen2", 16'(bus.code_out), 16'd4);
        chk("bp_valid_hold", 16'(bus.code_valid), 16'd1);
        sb.push_back(4'd4); sb.push_back(4'd10); bus.code_ready = 1'b1;
        tick(1);
        chk("bp_reload_code", 16'(bus.code_out), 16'd10);
        chk("bp_reload_valid", 16'(bus.code_valid), 16'd1);
        tick(1);
        chk("bp_done", 16'(bus.code_valid), 16'd0);
`ifdef PTC_TB_CHECK_EN
        chk("tb_pre_err", 16'(onehot_err), 16'd0);
        t_in = 16'h0008; sb.push_back(4'd4);
        tick(10);
        chk("tb_code", 16'(bus.code_out), 16'd4);
        tb_flip = 16'h0008;
        tick(5);
        chk("tb_err", 16'(onehot_err), 16'd1);
        chk("tb_locked", 16'(locked), 16'd0);
`endif
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
